id_ex_stage: RTL
================

Name:
id_ex_stage

Overview:
ID/EX pipeline register directly upstream of the ALU. It latches decoded operands and control from ID, registers the 4-bit ALU control code decoded from funct/aluOp, and applies EX-stage forwarding muxes. Its outputs drive aluSrc1/aluSrc2/aluCtrl of the ALU and carry memory/writeback control to EX/MEM.

Parameters:
DATA_W, 32, operand/result width
RADDR_W, 5, register address width

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous reset, active-low
stall_i  in  1  hold all stage registers
flush_i  in  1  load a bubble
valid_i  in  1  ID holds a real instruction
rs1Data_i  in  DATA_W  register-file read 1
rs2Data_i  in  DATA_W  register-file read 2
imm_i  in  DATA_W  sign-extended immediate
funct_i  in  10  {funct7, funct3}
aluOp_i  in  2  00 load/store, 01 I-type arith, 10 R-type, 11 branch
aluSrc_i  in  1  1 = immediate as operand 2
ctrl_i  in  4  {regWrite, memRead, memWrite, memToReg}
rsAddr_i  in  2*RADDR_W  {rs1, rs2}
rdAddr_i  in  RADDR_W  destination register
fwdSel_i  in  4  {fwdA[1:0], fwdB[1:0]}: 00 register, 10 EX/MEM, 01 MEM/WB, 11 register
exMemResult_i  in  DATA_W  EX/MEM forwarded value
memWbResult_i  in  DATA_W  MEM/WB forwarded value
valid_o  out  1  stage holds a real instruction
aluSrc1_o  out  DATA_W  ALU operand 1 (forwarded rs1)
aluSrc2_o  out  DATA_W  ALU operand 2 (imm or forwarded rs2)
aluCtrl_o  out  4  registered ALU control code
storeData_o  out  DATA_W  forwarded rs2, for stores
ctrl_o  out  4  registered ctrl_i
rsAddr_o  out  2*RADDR_W  registered rsAddr_i, to forwarding unit
rdAddr_o  out  RADDR_W  registered rdAddr_i

Behaviour:
- Reset (rst_i low, asynchronous): every register cleared to 0. valid_o=0, ctrl_o=0, aluCtrl_o=4'b0000. aluSrc1_o/aluSrc2_o then follow the forwarding muxes over zeroed registers.
- Register update priority each edge: flush_i > stall_i > load. flush_i with stall_i: bubble wins.
- Bubble: valid, ctrl, aluCtrl, data and addresses all registered as 0.
- Stall: all registers hold. Forwarding muxes stay live, so operands track exMemResult_i/memWbResult_i.
- Load: all inputs captured. valid_o is captured from valid_i. When valid_i=0, ctrl is forced to 0.
- Latency: one cycle from ID input to registered outputs. Forwarding and the aluSrc mux are combinational after the register, with no added cycle.
- aluCtrl decode (combinational, before register):
  - aluOp 00 -> 0010; 01 -> 0010; 11 -> 0110.
  - aluOp 10, by funct: 0000000111 -> 0000, 0000000110 -> 0001, 0000000000 -> 0010, 0100000000 -> 0110, 0000001000 -> 0011. Any other funct -> 0010.
- Operand path: fwdA selects aluSrc1_o. fwdB selects storeData_o. aluSrc2_o = registered aluSrc ? registered imm : storeData_o. Select code 11 behaves as 00.
- Widths: no arithmetic here. Every data path is exactly DATA_W with no extension.

Optional Feature:
IDEX_ILLEGAL_FLAG_EN. With it: extra output illegal_o (1 bit) is registered, set when a loaded valid instruction has aluOp=10 and an unlisted funct, and cleared by reset, flush or any non-illegal load. It holds on stall. Without it: no port; unlisted funct decodes silently to 0010.

Decomposition:
- Package alu_pkg holds the ALU_CTRL_* codes (AND/OR/ADD/SUB/MUL), the ALUOP_* codes, the FUNCT_* constants and the FWD_* select codes.
- One natural sub-module: alu_ctrl_dec, the combinational aluOp/funct to aluCtrl decoder, shared with other decoders.

Test Plan:
- Reset mid-operation, with valid_i=1 and ctrl_i=4'hF loaded -> within the same cycle valid_o=0, ctrl_o=0, aluCtrl_o=0000.
- R-type sub (funct=0100000000, aluOp=10), rs1=7, rs2=3, fwd=00 -> next cycle aluCtrl_o=0110, aluSrc1_o=7, aluSrc2_o=3.
- addi (aluOp=01, aluSrc=1), imm=-4, rs2=9 -> aluSrc2_o=32'hFFFFFFFC, storeData_o=9, aluCtrl_o=0010.
- Forwarding with fwdSel=4'b1001, exMem=100, memWb=200 -> aluSrc1_o=100, storeData_o=200. Changing exMem to 5 during a stall gives aluSrc1_o=5 in the same cycle, registers unchanged.
- flush_i and stall_i asserted together with a valid mul input -> next cycle valid_o=0, ctrl_o=0, aluCtrl_o=0000. A following load of mul gives aluCtrl_o=0011.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU encodings: control codes, aluOp classes, R-type funct values and forwarding selects.
package alu_pkg;

  localparam logic [3:0] ALU_CTRL_AND = 4'b0000;
  localparam logic [3:0] ALU_CTRL_OR  = 4'b0001;
  localparam logic [3:0] ALU_CTRL_ADD = 4'b0010;
  localparam logic [3:0] ALU_CTRL_MUL = 4'b0011;
  localparam logic [3:0] ALU_CTRL_SUB = 4'b0110;

  localparam logic [1:0] ALUOP_MEM    = 2'b00;
  localparam logic [1:0] ALUOP_IMM    = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_BRANCH = 2'b11;

  // {funct7, funct3}
  localparam logic [9:0] FUNCT_AND = 10'b0000000111;
  localparam logic [9:0] FUNCT_OR  = 10'b0000000110;
  localparam logic [9:0] FUNCT_ADD = 10'b0000000000;
  localparam logic [9:0] FUNCT_SUB = 10'b0100000000;
  localparam logic [9:0] FUNCT_MUL = 10'b0000001000;

  localparam logic [1:0] FWD_REG     = 2'b00;
  localparam logic [1:0] FWD_MEMWB   = 2'b01;
  localparam logic [1:0] FWD_EXMEM   = 2'b10;
  localparam logic [1:0] FWD_REG_ALT = 2'b11;

  function automatic logic isListedFunct(input logic [9:0] funct);
    return (funct == FUNCT_AND) || (funct == FUNCT_OR) || (funct == FUNCT_ADD) ||
           (funct == FUNCT_SUB) || (funct == FUNCT_MUL);
  endfunction

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational aluOp/funct to 4-bit ALU control decoder; unlisted R-type funct falls back to ADD.
module alu_ctrl_dec
  import alu_pkg::*;
(
  input  logic [1:0] aluOp,
  input  logic [9:0] funct,
  output logic [3:0] aluCtrl
);

  always_comb begin
    aluCtrl = ALU_CTRL_ADD;
    case (aluOp)
      ALUOP_BRANCH: aluCtrl = ALU_CTRL_SUB;
      ALUOP_RTYPE: begin
        case (funct)
          FUNCT_AND: aluCtrl = ALU_CTRL_AND;
          FUNCT_OR:  aluCtrl = ALU_CTRL_OR;
          FUNCT_ADD: aluCtrl = ALU_CTRL_ADD;
          FUNCT_SUB: aluCtrl = ALU_CTRL_SUB;
          FUNCT_MUL: aluCtrl = ALU_CTRL_MUL;
          default:   aluCtrl = ALU_CTRL_ADD;
        endcase
      end
      default: aluCtrl = ALU_CTRL_ADD;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with live EX-stage forwarding muxes in front of the ALU.
// Optional IDEX_ILLEGAL_FLAG_EN adds a registered illegal_o for unlisted R-type funct.
module id_ex_stage
  import alu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 stall_i,
  input  logic                 flush_i,
  input  logic                 valid_i,
  input  logic [DATA_W-1:0]    rs1Data_i,
  input  logic [DATA_W-1:0]    rs2Data_i,
  input  logic [DATA_W-1:0]    imm_i,
  input  logic [9:0]           funct_i,
  input  logic [1:0]           aluOp_i,
  input  logic                 aluSrc_i,
  input  logic [3:0]           ctrl_i,
  input  logic [2*RADDR_W-1:0] rsAddr_i,
  input  logic [RADDR_W-1:0]   rdAddr_i,
  input  logic [3:0]           fwdSel_i,
  input  logic [DATA_W-1:0]    exMemResult_i,
  input  logic [DATA_W-1:0]    memWbResult_i,
`ifdef IDEX_ILLEGAL_FLAG_EN
  output logic                 illegal_o,
`endif
  output logic                 valid_o,
  output logic [DATA_W-1:0]    aluSrc1_o,
  output logic [DATA_W-1:0]    aluSrc2_o,
  output logic [3:0]           aluCtrl_o,
  output logic [DATA_W-1:0]    storeData_o,
  output logic [3:0]           ctrl_o,
  output logic [2*RADDR_W-1:0] rsAddr_o,
  output logic [RADDR_W-1:0]   rdAddr_o
);

  logic [3:0] aluCtrl_p0;

  logic                 vld_p1;
  logic [DATA_W-1:0]    rs1Data_p1;
  logic [DATA_W-1:0]    rs2Data_p1;
  logic [DATA_W-1:0]    imm_p1;
  logic                 aluSrc_p1;
  logic [3:0]           aluCtrl_p1;
  logic [3:0]           ctrl_p1;
  logic [2*RADDR_W-1:0] rsAddr_p1;
  logic [RADDR_W-1:0]   rdAddr_p1;

  alu_ctrl_dec uDec (
    .aluOp   (aluOp_i),
    .funct   (funct_i),
    .aluCtrl (aluCtrl_p0)
  );

  // ID -> EX boundary: flush beats stall, stall beats load
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      vld_p1     <= 1'b0;
      rs1Data_p1 <= '0;
      rs2Data_p1 <= '0;
      imm_p1     <= '0;
      aluSrc_p1  <= 1'b0;
      aluCtrl_p1 <= '0;
      ctrl_p1    <= '0;
      rsAddr_p1  <= '0;
      rdAddr_p1  <= '0;
    end else if (flush_i) begin
      vld_p1     <= 1'b0;
      rs1Data_p1 <= '0;
      rs2Data_p1 <= '0;
      imm_p1     <= '0;
      aluSrc_p1  <= 1'b0;
      aluCtrl_p1 <= '0;
      ctrl_p1    <= '0;
      rsAddr_p1  <= '0;
      rdAddr_p1  <= '0;
    end else if (!stall_i) begin
      vld_p1     <= valid_i;
      rs1Data_p1 <= rs1Data_i;
      rs2Data_p1 <= rs2Data_i;
      imm_p1     <= imm_i;
      aluSrc_p1  <= aluSrc_i;
      aluCtrl_p1 <= aluCtrl_p0;
      ctrl_p1    <= valid_i ? ctrl_i : 4'b0000;
      rsAddr_p1  <= rsAddr_i;
      rdAddr_p1  <= rdAddr_i;
    end
  end

`ifdef IDEX_ILLEGAL_FLAG_EN
  logic illegal_p1;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      illegal_p1 <= 1'b0;
    end else if (flush_i) begin
      illegal_p1 <= 1'b0;
    end else if (!stall_i) begin
      illegal_p1 <= valid_i && (aluOp_i == ALUOP_RTYPE) && !isListedFunct(funct_i);
    end
  end

  assign illegal_o = illegal_p1;
`endif

  // Code 11 is treated like 00 so a stale forwarding unit can never pick garbage
  function automatic logic [DATA_W-1:0] fwdMux(input logic [1:0] sel,
                                               input logic [DATA_W-1:0] regVal,
                                               input logic [DATA_W-1:0] exMem,
                                               input logic [DATA_W-1:0] memWb);
    case (sel)
      FWD_EXMEM: return exMem;
      FWD_MEMWB: return memWb;
      default:   return regVal;
    endcase
  endfunction

  // EX side: forwarding stays live through stalls
  assign aluSrc1_o   = fwdMux(fwdSel_i[3:2], rs1Data_p1, exMemResult_i, memWbResult_i);
  assign storeData_o = fwdMux(fwdSel_i[1:0], rs2Data_p1, exMemResult_i, memWbResult_i);
  assign aluSrc2_o   = aluSrc_p1 ? imm_p1 : storeData_o;

  assign valid_o   = vld_p1;
  assign aluCtrl_o = aluCtrl_p1;
  assign ctrl_o    = ctrl_p1;
  assign rsAddr_o  = rsAddr_p1;
  assign rdAddr_o  = rdAddr_p1;

endmodule
